eth_tx_sched: RTL and testbench

Round-robin scheduler that shares one port's TX packet queue between NSRC packet sources: the other ports' RX queues forwarding through the switch, plus the ARM TXQA queue. It polls the sources' availability and length, checks free space in the TX queue, and pulses the one-cycle read strobe to the chosen source. It then re-emits that source's 64-bit beats as a framed sop/eop stream into the TX queue. It sits in the forwarding switch, one instance per egress port.

---
 rtl/eth_tx_sched_pkg.sv | 47 ++++
 rtl/eth_tx_sched_rr_pick.sv | 44 ++++
 rtl/eth_tx_sched.sv | 214 +++++++++++++++++++++
 tb/tb_eth_tx_sched.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_tx_sched_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : eth_tx_sched_pkg
// Description : Shared widths, limits, state encoding and TX-queue beat record
//               for the egress-port TX scheduler.
// Revision    : 1.0  initial release
// ============================================================================
package eth_tx_sched_pkg;

  localparam int PCKT_Q_INTF_W           = 64;    // beat width
  localparam int MAX_ETH_FRAME_CNT_WIDTH = 11;    // length field width
  localparam int MEM_ETH_ADDR_W_EXT_TX   = 12;    // TX queue free-space width
  localparam int BITS_PAD                = 3;     // log2(bytes per beat)
  localparam int MIN_ETH_FRAME_CNT       = 60;
  localparam int MAX_ETH_FRAME_CNT       = 1518;
  localparam int BEAT_CNT_W              = MAX_ETH_FRAME_CNT_WIDTH - BITS_PAD;

  typedef enum logic [2:0] {
    TXS_IDLE = 3'd0,
    TXS_ARB  = 3'd1,
    TXS_REQ  = 3'd2,
    TXS_XFER = 3'd3,
    TXS_GAP  = 3'd4
  } tx_sched_state_t;

  typedef struct packed {
    logic                               val;
    logic                               sop;
    logic                               eop;
    logic [BITS_PAD-1:0]                offs;
    logic [PCKT_Q_INTF_W-1:0]           data;
    logic [MAX_ETH_FRAME_CNT_WIDTH-1:0] lnb;
  } pack_q_frw_tx_from_sw_t;

  // ceil(lnb/8). The carry out of the top bit is dropped: it only occurs for
  // lengths far above MAX_ETH_FRAME_CNT, which are never granted.
  function automatic logic [BEAT_CNT_W-1:0] lnb_to_beats(
    input logic [MAX_ETH_FRAME_CNT_WIDTH-1:0] lnb
  );
    logic [MAX_ETH_FRAME_CNT_WIDTH:0] sum;
    sum = {1'b0, lnb} + (MAX_ETH_FRAME_CNT_WIDTH+1)'(7);
    return sum[MAX_ETH_FRAME_CNT_WIDTH-1:BITS_PAD];
  endfunction

endpackage
`default_nettype wire

// File: rtl/eth_tx_sched_rr_pick.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : eth_tx_sched_rr_pick
// Description : Combinational round-robin picker. Scans req cyclically
//               starting at ptr+1 and returns the first set index.
// Ports       : req   - request vector
//               ptr   - last granted index
//               found - any request set
//               idx   - winning index (0 when none)
// Revision    : 1.0  initial release
// ============================================================================
module eth_tx_sched_rr_pick #(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // w_cand[g] is the index visited at scan position g.
  logic [IDX_W-1:0] w_cand [N];

  for (genvar g = 0; g < N; g++) begin : g_cand
    assign w_cand[g] = IDX_W'((int'(ptr) + g + 1) % N);
  end

  // Walk from the last scan position back to the first so the earliest
  // position overwrites later ones; no early exit is needed.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[w_cand[i]]) begin
        found = 1'b1;
        idx   = w_cand[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/eth_tx_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : eth_tx_sched
// Description : Round-robin scheduler feeding one egress TX queue from NSRC
//               packet sources (index NSRC-1 is the ARM queue). Arbitrates,
//               strobes the winner, and reframes its beats as sop/eop.
// Ports       : clk, rst_n (async, active low), ena
//               src_avlb/src_lnb/src_val/src_data  - source side inputs
//               src_strb/src_drop                  - source read/discard pulses
//               q_bytes_avlb                       - TX queue free space
//               tx_val/sop/eop/offs/data/lnb/abort - TX queue beat stream
//               busy, cur_src, len_err_cnt, tmo_cnt - status
// Revision    : 1.0  initial release
// ============================================================================
module eth_tx_sched
  import eth_tx_sched_pkg::*;
#(
  parameter int NSRC    = 3,
  parameter int TMO_CYC = 256,
  parameter int MIN_LNB = MIN_ETH_FRAME_CNT,
  parameter int MAX_LNB = MAX_ETH_FRAME_CNT,
  localparam int SRC_W  = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         ena,
  input  logic [NSRC-1:0]                              src_avlb,
  input  logic [NSRC-1:0][MAX_ETH_FRAME_CNT_WIDTH-1:0] src_lnb,
  output logic [NSRC-1:0]                              src_strb,
  output logic [NSRC-1:0]                              src_drop,
  input  logic [NSRC-1:0]                              src_val,
  input  logic [NSRC-1:0][PCKT_Q_INTF_W-1:0]           src_data,
  input  logic [MEM_ETH_ADDR_W_EXT_TX-1:0]             q_bytes_avlb,
  output logic                                         tx_val,
  output logic                                         tx_sop,
  output logic                                         tx_eop,
  output logic [BITS_PAD-1:0]                          tx_offs,
  output logic [PCKT_Q_INTF_W-1:0]                     tx_data,
  output logic [MAX_ETH_FRAME_CNT_WIDTH-1:0]           tx_lnb,
  output logic                                         tx_abort,
  output logic                                         busy,
  output logic [SRC_W-1:0]                             cur_src,
  output logic [7:0]                                   len_err_cnt,
  output logic [7:0]                                   tmo_cnt
);

  localparam int IDLE_W = $clog2(TMO_CYC + 1);

  tx_sched_state_t                    state_q,    state_d;
  logic [SRC_W-1:0]                   rr_ptr_q,   rr_ptr_d;
  logic [SRC_W-1:0]                   cur_src_q,  cur_src_d;
  logic [MAX_ETH_FRAME_CNT_WIDTH-1:0] lnb_q,      lnb_d;
  logic [BEAT_CNT_W-1:0]              beats_q,    beats_d;
  logic [BEAT_CNT_W-1:0]              beat_cnt_q, beat_cnt_d;
  logic [IDLE_W-1:0]                  idle_q,     idle_d;
  logic [7:0]                         len_err_q,  len_err_d;
  logic [7:0]                         tmo_q,      tmo_d;
  logic [NSRC-1:0]                    strb_q,     strb_d;
  logic [NSRC-1:0]                    drop_q,     drop_d;
  pack_q_frw_tx_from_sw_t             tx_q,       tx_d;
  logic                               abort_q,    abort_d;

  logic                               w_found;
  logic [SRC_W-1:0]                   w_pick_idx;
  logic [MAX_ETH_FRAME_CNT_WIDTH-1:0] w_pick_lnb;
  logic                               w_len_bad;
  logic                               w_room;

  eth_tx_sched_rr_pick #(
    .N     (NSRC),
    .IDX_W (SRC_W)
  ) u_rr_pick (
    .req   (src_avlb),
    .ptr   (rr_ptr_q),
    .found (w_found),
    .idx   (w_pick_idx)
  );

  assign w_pick_lnb = src_lnb[w_pick_idx];
  assign w_len_bad  = (int'(w_pick_lnb) < MIN_LNB) || (int'(w_pick_lnb) > MAX_LNB);
  assign w_room     = q_bytes_avlb >= MEM_ETH_ADDR_W_EXT_TX'(w_pick_lnb);

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    cur_src_d  = cur_src_q;
    lnb_d      = lnb_q;
    beats_d    = beats_q;
    beat_cnt_d = beat_cnt_q;
    idle_d     = idle_q;
    len_err_d  = len_err_q;
    tmo_d      = tmo_q;
    strb_d     = '0;
    drop_d     = '0;
    tx_d       = '0;
    tx_d.lnb   = tx_q.lnb;        // length stays on the bus between beats
    abort_d    = 1'b0;

    unique case (state_q)
      TXS_IDLE: begin
        if (ena) state_d = TXS_ARB;
      end

      TXS_ARB: begin
        if (w_found) begin
          if (w_len_bad) begin
            drop_d[w_pick_idx] = 1'b1;
            if (len_err_q != 8'hFF) len_err_d = len_err_q + 8'd1;
            state_d = TXS_GAP;
          end else if (w_room) begin
            cur_src_d          = w_pick_idx;
            lnb_d              = w_pick_lnb;
            beats_d            = lnb_to_beats(w_pick_lnb);
            rr_ptr_d           = w_pick_idx;
            strb_d[w_pick_idx] = 1'b1;
            state_d            = TXS_REQ;
          end
          // Winner without room: hold the pointer and rescan, so the same
          // source keeps head-of-line priority until space frees up.
        end else if (!ena) begin
          state_d = TXS_IDLE;
        end
      end

      TXS_REQ: begin
        beat_cnt_d = '0;
        idle_d     = '0;
        state_d    = TXS_XFER;
      end

      TXS_XFER: begin
        if (src_val[cur_src_q]) begin
          tx_d.val   = 1'b1;
          tx_d.sop   = (beat_cnt_q == '0);
          tx_d.data  = src_data[cur_src_q];
          tx_d.lnb   = lnb_q;
          beat_cnt_d = beat_cnt_q + BEAT_CNT_W'(1);
          idle_d     = '0;
          if (beat_cnt_q == beats_q - BEAT_CNT_W'(1)) begin
            tx_d.eop  = 1'b1;
            tx_d.offs = lnb_q[BITS_PAD-1:0];
            state_d   = TXS_GAP;
          end
        end else if (idle_q == IDLE_W'(TMO_CYC - 1)) begin
          // Source went silent: close the frame with a zero abort beat.
          tx_d.val = 1'b1;
          tx_d.sop = (beat_cnt_q == '0);
          tx_d.eop = 1'b1;
          tx_d.lnb = lnb_q;
          abort_d  = 1'b1;
          if (tmo_q != 8'hFF) tmo_d = tmo_q + 8'd1;
          state_d  = TXS_GAP;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end

      TXS_GAP: begin
        state_d = ena ? TXS_ARB : TXS_IDLE;
      end

      default: state_d = TXS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= TXS_IDLE;
      rr_ptr_q   <= SRC_W'(NSRC - 1);
      cur_src_q  <= '0;
      lnb_q      <= '0;
      beats_q    <= '0;
      beat_cnt_q <= '0;
      idle_q     <= '0;
      len_err_q  <= '0;
      tmo_q      <= '0;
      strb_q     <= '0;
      drop_q     <= '0;
      tx_q       <= '0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      cur_src_q  <= cur_src_d;
      lnb_q      <= lnb_d;
      beats_q    <= beats_d;
      beat_cnt_q <= beat_cnt_d;
      idle_q     <= idle_d;
      len_err_q  <= len_err_d;
      tmo_q      <= tmo_d;
      strb_q     <= strb_d;
      drop_q     <= drop_d;
      tx_q       <= tx_d;
      abort_q    <= abort_d;
    end
  end

  assign src_strb    = strb_q;
  assign src_drop    = drop_q;
  assign tx_val      = tx_q.val;
  assign tx_sop      = tx_q.sop;
  assign tx_eop      = tx_q.eop;
  assign tx_offs     = tx_q.offs;
  assign tx_data     = tx_q.data;
  assign tx_lnb      = tx_q.lnb;
  assign tx_abort    = abort_q;
  assign busy        = (state_q != TXS_IDLE);
  assign cur_src     = cur_src_q;
  assign len_err_cnt = len_err_q;
  assign tmo_cnt     = tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_eth_tx_sched
// Description : Directed self-checking bench for eth_tx_sched. A behavioural
//               source model answers strobes with patterned beats while the
//               other sources chatter with stray src_val; a monitor collects
//               the TX stream into per-packet records.
// Revision    : 1.0  initial release
// ============================================================================
module tb_eth_tx_sched;
  import eth_tx_sched_pkg::*;

  localparam int NSRC = 3;
  localparam int TMO  = 256;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    ena = 1'b0;
  logic [NSRC-1:0]         src_avlb = '0;
  logic [NSRC-1:0][10:0]   src_lnb = '0;
  logic [NSRC-1:0]         src_strb, src_drop;
  logic [NSRC-1:0]         src_val = '0;
  logic [NSRC-1:0][63:0]   src_data = '0;
  logic [11:0]             q_bytes_avlb = 12'd2048;
  logic                    tx_val, tx_sop, tx_eop, tx_abort, busy;
  logic [2:0]              tx_offs;
  logic [63:0]             tx_data;
  logic [10:0]             tx_lnb;
  logic [1:0]              cur_src;
  logic [7:0]              len_err_cnt, tmo_cnt;

  eth_tx_sched #(.NSRC(NSRC), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .src_avlb(src_avlb), .src_lnb(src_lnb), .src_strb(src_strb), .src_drop(src_drop),
    .src_val(src_val), .src_data(src_data), .q_bytes_avlb(q_bytes_avlb),
    .tx_val(tx_val), .tx_sop(tx_sop), .tx_eop(tx_eop), .tx_offs(tx_offs),
    .tx_data(tx_data), .tx_lnb(tx_lnb), .tx_abort(tx_abort), .busy(busy),
    .cur_src(cur_src), .len_err_cnt(len_err_cnt), .tmo_cnt(tmo_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int s, input int k);
    return 64'hC0DE_0000_0000_0000 | (64'(s) << 32) | 64'(k);
  endfunction

  // ---------------- source model state ----------------
  int npk [NSRC];
  int stall_after [NSRC];
  bit act = 0;
  int act_src, act_k, act_left, act_stall;
  int strb_cnt [NSRC];
  int drop_cnt [NSRC];
  int txv_cnt;
  int grant_q [$];
  int cyc = 0;

  // ---------------- monitor state ----------------
  typedef struct {
    int src; int nbeats; int offs; int lnb; bit abort; bit frame_ok; bit data_ok; int gap;
  } pkt_t;
  pkt_t pkt_q [$];
  int m_k = 0, m_src = 0, m_lnb = 0, m_last = 0;
  bit m_ok, m_dok;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      act     = 0;
      m_k     = 0;
      src_val = '0;
    end else begin
      if (tx_val) begin
        pkt_t p;
        txv_cnt++;
        if (m_k == 0) begin
          m_src = int'(tx_data[47:32]);
          m_lnb = int'(tx_lnb);
          m_ok  = tx_sop;
          m_dok = 1;
        end else if (tx_sop) m_ok = 0;
        if (int'(tx_lnb) != m_lnb) m_ok = 0;
        if (!tx_eop && (tx_offs != 3'd0 || tx_abort)) m_ok = 0;
        if (tx_abort) begin
          if (tx_data != 64'd0) m_dok = 0;
        end else if (tx_data != pat(m_src, m_k)) m_dok = 0;
        p.gap  = cyc - m_last;
        m_last = cyc;
        m_k++;
        if (tx_eop) begin
          p.src = m_src; p.nbeats = m_k; p.offs = int'(tx_offs); p.lnb = m_lnb;
          p.abort = tx_abort; p.frame_ok = m_ok; p.data_ok = m_dok;
          pkt_q.push_back(p);
          m_k = 0;
        end
      end
      // Granted source streams its beats; every other source chatters.
      for (int s = 0; s < NSRC; s++) begin
        src_val[s]  = 1'b1;
        src_data[s] = 64'hBAD0_BAD0_0000_0000 | 64'(s);
      end
      if (act) begin
        src_val[act_src]  = 1'b0;
        src_data[act_src] = '0;
        if (act_stall < 0 || act_k < act_stall) begin
          src_val[act_src]  = 1'b1;
          src_data[act_src] = pat(act_src, act_k);
          act_k++;
          if (act_k == act_left) act = 0;
        end
      end
      for (int s = 0; s < NSRC; s++) begin
        if (src_strb[s]) begin
          strb_cnt[s]++;
          grant_q.push_back(s);
          act       = 1;
          act_src   = s;
          act_k     = 0;
          act_left  = (int'(src_lnb[s]) + 7) / 8;
          act_stall = stall_after[s];
          if (npk[s] > 0) npk[s]--;
          if (npk[s] == 0) src_avlb[s] = 1'b0;
        end
        if (src_drop[s]) begin
          drop_cnt[s]++;
          src_avlb[s] = 1'b0;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    rst_n        = 1'b0;
    ena          = 1'b0;
    src_avlb     = '0;
    q_bytes_avlb = 12'd2048;
    for (int s = 0; s < NSRC; s++) begin
      npk[s] = 0; stall_after[s] = -1; src_lnb[s] = '0;
      strb_cnt[s] = 0; drop_cnt[s] = 0;
    end
    repeat (3) @(negedge clk);
    txv_cnt = 0;
    grant_q.delete();
    pkt_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic add_src(input int s, input int lnb, input int n, input int stall);
    src_lnb[s]     = 11'(lnb);
    npk[s]         = n;
    stall_after[s] = stall;
    src_avlb[s]    = 1'b1;
  endtask

  task automatic wait_pkts(input string tag, input int n, input int budget);
    int c = 0;
    while (pkt_q.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    #1;
    check_val({tag, "_npkts"}, 64'(pkt_q.size()), 64'(n));
  endtask

  task automatic check_pkt(input string tag, input int i, input int src, input int nb,
                           input int offs, input int lnb, input bit abort);
    if (pkt_q.size() > i) begin
      check_val({tag, "_src"},   64'(pkt_q[i].src),    64'(src));
      check_val({tag, "_beats"}, 64'(pkt_q[i].nbeats), 64'(nb));
      check_val({tag, "_offs"},  64'(pkt_q[i].offs),   64'(offs));
      check_val({tag, "_lnb"},   64'(pkt_q[i].lnb),    64'(lnb));
      check_val({tag, "_abort"}, 64'(pkt_q[i].abort),  64'(abort));
      check_val({tag, "_frame"}, 64'(pkt_q[i].frame_ok), 64'd1);
      check_val({tag, "_data"},  64'(pkt_q[i].data_ok),  64'd1);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset state ----
    do_reset();
    #1;
    check_val("rst_flags", {57'd0, tx_val, tx_sop, tx_eop, tx_abort, busy, src_strb != 0, src_drop != 0}, 64'd0);
    check_val("rst_data",  tx_data, 64'd0);
    check_val("rst_lnb",   64'(tx_lnb), 64'd0);
    check_val("rst_cnts",  {48'd0, len_err_cnt, tmo_cnt}, 64'd0);
    check_val("rst_cur",   64'(cur_src), 64'd0);

    // ---- single source 0, 64 bytes; held off until ena ----
    add_src(0, 64, 1, -1);
    repeat (5) @(negedge clk);
    #1;
    check_val("ena0_strb", 64'(strb_cnt[0]), 64'd0);
    check_val("ena0_busy", 64'(busy), 64'd0);
    ena = 1'b1;
    wait_pkts("t1", 1, 60);
    check_pkt("t1", 0, 0, 8, 0, 64, 0);
    check_val("t1_strb", 64'(strb_cnt[0]), 64'd1);
    check_val("t1_txv", 64'(txv_cnt), 64'd8);

    // ---- round robin over three sources, 61 bytes each ----
    do_reset();
    add_src(0, 61, 2, -1);
    add_src(1, 61, 1, -1);
    add_src(2, 61, 1, -1);
    ena = 1'b1;
    wait_pkts("rr", 4, 200);
    check_pkt("rr0", 0, 0, 8, 5, 61, 0);
    check_pkt("rr1", 1, 1, 8, 5, 61, 0);
    check_pkt("rr2", 2, 2, 8, 5, 61, 0);
    check_pkt("rr3", 3, 0, 8, 5, 61, 0);

    // ---- head-of-line wait for TX queue space ----
    do_reset();
    q_bytes_avlb = 12'd1000;
    add_src(1, 1518, 1, -1);
    ena = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    check_val("hol_strb", 64'(strb_cnt[1]), 64'd0);
    check_val("hol_busy", 64'(busy), 64'd1);
    @(negedge clk);
    q_bytes_avlb = 12'd1600;
    begin
      int c = 0;
      while (strb_cnt[1] == 0 && c < 2) begin
        @(negedge clk);
        #1;
        c++;
      end
    end
    check_val("hol_grant", 64'(strb_cnt[1]), 64'd1);
    check_val("hol_cur", 64'(cur_src), 64'd1);
    wait_pkts("hol", 1, 300);
    check_pkt("hol", 0, 1, 190, 6, 1518, 0);

    // ---- length errors: too short, then too long ----
    do_reset();
    add_src(0, 20, 1, -1);
    ena = 1'b1;
    begin
      int c = 0;
      while (drop_cnt[0] < 1 && c < 20) begin @(negedge clk); c++; end
    end
    #1;
    check_val("short_drop", 64'(drop_cnt[0]), 64'd1);
    check_val("short_err",  64'(len_err_cnt), 64'd1);
    @(negedge clk);
    add_src(0, 2000, 1, -1);
    begin
      int c = 0;
      while (drop_cnt[0] < 2 && c < 20) begin @(negedge clk); c++; end
    end
    repeat (3) @(negedge clk);
    #1;
    check_val("long_drop", 64'(drop_cnt[0]), 64'd2);
    check_val("long_err",  64'(len_err_cnt), 64'd2);
    check_val("len_txv",   64'(txv_cnt), 64'd0);
    check_val("len_strb",  64'(strb_cnt[0]), 64'd0);

    // ---- source stalls after 3 beats: timeout abort, then next source ----
    do_reset();
    add_src(0, 64, 1, 3);
    add_src(1, 64, 1, -1);
    ena = 1'b1;
    wait_pkts("tmo", 2, 700);
    check_pkt("tmo0", 0, 0, 4, 0, 64, 1);
    check_pkt("tmo1", 1, 1, 8, 0, 64, 0);
    if (pkt_q.size() > 0) check_val("tmo_gap", 64'(pkt_q[0].gap), 64'(TMO));
    check_val("tmo_cnt", 64'(tmo_cnt), 64'd1);

    // ---- reset in the middle of a transfer ----
    do_reset();
    add_src(0, 1518, 1, -1);
    ena = 1'b1;
    begin
      int c = 0;
      while (txv_cnt < 5 && c < 50) begin @(negedge clk); c++; end
    end
    #1;
    check_val("mid_xfer_busy", 64'(busy), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_flags", {57'd0, tx_val, tx_sop, tx_eop, tx_abort, busy, src_strb != 0, src_drop != 0}, 64'd0);
    check_val("mid_rst_data", tx_data, 64'd0);
    check_val("mid_rst_lnb", 64'(tx_lnb), 64'd0);
    do_reset();
    add_src(1, 64, 1, -1);
    add_src(0, 64, 1, -1);
    ena = 1'b1;
    wait_pkts("post", 2, 100);
    check_val("post_g0", 64'(grant_q.size() > 0 ? grant_q[0] : -1), 64'd0);
    check_val("post_g1", 64'(grant_q.size() > 1 ? grant_q[1] : -1), 64'd1);
    check_pkt("post0", 0, 0, 8, 0, 64, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
